// File: rtl/demux1x4_reg.sv
// demux1x4_reg: routes one WIDTH-bit bus into one of four lane registers
// (OA..OD, feeding the 4:1 datapath mux inputs A-D). Tracks per-lane
// "loaded" flags and a saturating count of accepted writes.
// Optional feature: define DEMUX_BROADCAST_EN to add the bcast input, which
// writes I into all four lanes as a single write.
module demux1x4_reg #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       sw,
  input  logic             en,
  input  logic             clr,
`ifdef DEMUX_BROADCAST_EN
  input  logic             bcast,
`endif
  output logic [WIDTH-1:0] OA,
  output logic [WIDTH-1:0] OB,
  output logic [WIDTH-1:0] OC,
  output logic [WIDTH-1:0] OD,
  output logic [3:0]       loaded,
  output logic [CNT_W-1:0] wr_cnt
);

  logic [3:0]       we_c;
  logic             accept_c;
  logic [3:0]       loaded_nxt_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Decode the write strobe into per-lane enables; an unmatched select writes nothing
  always_comb begin
    we_c     = 4'b0000;
    accept_c = 1'b0;
`ifdef DEMUX_BROADCAST_EN
    if (en && bcast) begin
      we_c     = 4'b1111;
      accept_c = 1'b1;
    end else
`endif
    if (en) begin
      case (sw)
        2'b00:   begin we_c = 4'b0001; accept_c = 1'b1; end
        2'b01:   begin we_c = 4'b0010; accept_c = 1'b1; end
        2'b10:   begin we_c = 4'b0100; accept_c = 1'b1; end
        2'b11:   begin we_c = 4'b1000; accept_c = 1'b1; end
        default: begin we_c = 4'b0000; accept_c = 1'b0; end
      endcase
    end
  end

  // Flag/count next state: clear first, then a same-edge write re-marks its own lane and counts once
  always_comb begin
    loaded_nxt_c = (clr ? 4'b0000 : loaded) | we_c;
    cnt_nxt_c    = wr_cnt;
    if (accept_c) begin
      if (clr)
        cnt_nxt_c = CNT_W'(1);
      else if (wr_cnt != {CNT_W{1'b1}})
        cnt_nxt_c = wr_cnt + CNT_W'(1);
    end else if (clr) begin
      cnt_nxt_c = '0;
    end
  end

  // Lane registers: only enabled lanes capture I
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OA <= '0;
      OB <= '0;
      OC <= '0;
      OD <= '0;
    end else begin
      if (we_c[0]) OA <= I;
      if (we_c[1]) OB <= I;
      if (we_c[2]) OC <= I;
      if (we_c[3]) OD <= I;
    end
  end

  // Loaded flags and write counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded <= 4'b0000;
      wr_cnt <= '0;
    end else begin
      loaded <= loaded_nxt_c;
      wr_cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: tb/tb_demux1x4_reg.sv
// Self-checking bench for demux1x4_reg: constant vector table, hand-written
// corner sequences, then random traffic against a behavioural lane model.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_demux1x4_reg;
  localparam int unsigned WIDTH = 10;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             bcast = 1'b0;
  logic [1:0]       sw = 2'b00;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] oa, ob, oc, od;
  logic [WIDTH-1:0] oa2, ob2, oc2, od2;
  logic [3:0]       loaded, loaded2;
  logic [CNT_W-1:0] wr_cnt;
  logic [1:0]       wr_cnt2;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [WIDTH-1:0] m_lane [4];
  logic [3:0]       m_loaded;
  int               m_cnt, m_cnt2;

  always #5 clk = ~clk;

  demux1x4_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .I(din), .sw(sw), .en(en), .clr(clr),
`ifdef DEMUX_BROADCAST_EN
    .bcast(bcast),
`endif
    .OA(oa), .OB(ob), .OC(oc), .OD(od), .loaded(loaded), .wr_cnt(wr_cnt)
  );

  demux1x4_reg #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .I(din), .sw(sw), .en(en), .clr(clr),
`ifdef DEMUX_BROADCAST_EN
    .bcast(bcast),
`endif
    .OA(oa2), .OB(ob2), .OC(oc2), .OD(od2), .loaded(loaded2), .wr_cnt(wr_cnt2)
  );

  typedef struct {
    logic             en;
    logic [1:0]       sw;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] ea, eb, ec, ed;
    logic [3:0]       eld;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  vec_t vt [12];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_lane[k] = '0;
    m_loaded = 4'b0000;
    m_cnt    = 0;
    m_cnt2   = 0;
  endtask

  // One rising edge as the design should see it: which lanes get I, then flags/counts
  task automatic model_edge();
    logic [3:0] hit;
    logic       b;
    hit = 4'b0000;
`ifdef DEMUX_BROADCAST_EN
    b = bcast;
`else
    b = 1'b0;
`endif
    if (rst) begin
      model_reset();
      return;
    end
    if (en) hit = b ? 4'b1111 : (4'b0001 << sw);
    for (int k = 0; k < 4; k++) if (hit[k]) m_lane[k] = din;
    if (clr) begin
      m_loaded = 4'b0000;
      m_cnt    = 0;
      m_cnt2   = 0;
    end
    m_loaded = m_loaded | hit;
    if (hit != 4'b0000) begin
      m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
    end
  endtask

  task automatic check_model(input string nm);
    cmp({nm, " OA"}, 32'(oa), 32'(m_lane[0]));
    cmp({nm, " OB"}, 32'(ob), 32'(m_lane[1]));
    cmp({nm, " OC"}, 32'(oc), 32'(m_lane[2]));
    cmp({nm, " OD"}, 32'(od), 32'(m_lane[3]));
    cmp({nm, " loaded"}, 32'(loaded), 32'(m_loaded));
    cmp({nm, " wr_cnt"}, 32'(wr_cnt), 32'(m_cnt));
    cmp({nm, " wr_cnt2"}, 32'(wr_cnt2), 32'(m_cnt2));
  endtask

  // Apply inputs away from the edge, clock once, sample 1 time unit later
  task automatic step(input logic e, input logic [1:0] s, input logic c, input logic b,
                      input logic [WIDTH-1:0] d);
    en = e; sw = s; clr = c; bcast = b; din = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 2'd0, 1'b0, 10'h001, 10'h001, 10'h000, 10'h000, 10'h000, 4'b0001, 8'd1};
    vt[1]  = '{1'b1, 2'd1, 1'b0, 10'h007, 10'h001, 10'h007, 10'h000, 10'h000, 4'b0011, 8'd2};
    vt[2]  = '{1'b1, 2'd2, 1'b0, 10'h002, 10'h001, 10'h007, 10'h002, 10'h000, 4'b0111, 8'd3};
    vt[3]  = '{1'b1, 2'd3, 1'b0, 10'h003, 10'h001, 10'h007, 10'h002, 10'h003, 4'b1111, 8'd4};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 10'h3FF, 10'h001, 10'h007, 10'h002, 10'h003, 4'b1111, 8'd4};
    vt[5]  = '{1'b0, 2'd1, 1'b0, 10'h3FF, 10'h001, 10'h007, 10'h002, 10'h003, 4'b1111, 8'd4};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 10'h3FF, 10'h001, 10'h007, 10'h002, 10'h003, 4'b1111, 8'd4};
    vt[7]  = '{1'b0, 2'd3, 1'b0, 10'h3FF, 10'h001, 10'h007, 10'h002, 10'h003, 4'b1111, 8'd4};
    vt[8]  = '{1'b1, 2'd2, 1'b1, 10'h155, 10'h001, 10'h007, 10'h155, 10'h003, 4'b0100, 8'd1};
    vt[9]  = '{1'b1, 2'd2, 1'b0, 10'h0AA, 10'h001, 10'h007, 10'h0AA, 10'h003, 4'b0100, 8'd2};
    vt[10] = '{1'b1, 2'd2, 1'b0, 10'h0BB, 10'h001, 10'h007, 10'h0BB, 10'h003, 4'b0100, 8'd3};
    vt[11] = '{1'b0, 2'd1, 1'b1, 10'h3FF, 10'h001, 10'h007, 10'h0BB, 10'h003, 4'b0000, 8'd0};

    // Power-on reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset OA", 32'(oa), 32'h0);
    cmp("reset loaded", 32'(loaded), 32'h0);
    cmp("reset wr_cnt", 32'(wr_cnt), 32'h0);
    rst = 1'b0;

    // Vector table: lane fill, idle hold, clr+write, back-to-back, clr alone
    for (int k = 0; k < 12; k++) begin
      step(vt[k].en, vt[k].sw, vt[k].clr, 1'b0, vt[k].d);
      cmp($sformatf("tbl%0d OA", k), 32'(oa), 32'(vt[k].ea));
      cmp($sformatf("tbl%0d OB", k), 32'(ob), 32'(vt[k].eb));
      cmp($sformatf("tbl%0d OC", k), 32'(oc), 32'(vt[k].ec));
      cmp($sformatf("tbl%0d OD", k), 32'(od), 32'(vt[k].ed));
      cmp($sformatf("tbl%0d loaded", k), 32'(loaded), 32'(vt[k].eld));
      cmp($sformatf("tbl%0d wr_cnt", k), 32'(wr_cnt), 32'(vt[k].ecnt));
    end

    // One-cycle latency: new value absent before the edge, present after it
    en = 1'b1; sw = 2'd0; clr = 1'b0; bcast = 1'b0; din = 10'h123;
    #1;
    cmp("latency pre-edge OA", 32'(oa), 32'h001);
    step(1'b1, 2'd0, 1'b0, 1'b0, 10'h123);
    cmp("latency post-edge OA", 32'(oa), 32'h123);
    check_model("latency");

    // Async reset mid-cycle, held through an edge with en=1, then first write after release
    step(1'b0, 2'd0, 1'b0, 1'b0, 10'h000);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    cmp("async rst OA", 32'(oa), 32'h0);
    cmp("async rst OC", 32'(oc), 32'h0);
    cmp("async rst loaded", 32'(loaded), 32'h0);
    cmp("async rst wr_cnt", 32'(wr_cnt), 32'h0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 10'h2F0);
    cmp("rst held OB", 32'(ob), 32'h0);
    check_model("rst held");
    rst = 1'b0;
    step(1'b1, 2'd1, 1'b0, 1'b0, 10'h2F0);
    cmp("post-rst OB", 32'(ob), 32'h2F0);
    cmp("post-rst wr_cnt", 32'(wr_cnt), 32'h1);
    check_model("post-rst");

    // Saturation: CNT_W=2 instance 1,2,3,3,3; wide instance stops at 255
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 2'(k), 1'b0, 1'b0, 10'(k));
      cmp($sformatf("sat2 wr %0d", k), 32'(wr_cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    for (int k = 0; k < 255; k++) step(1'b1, 2'(k), 1'b0, 1'b0, 10'(k));
    cmp("sat8 wr_cnt", 32'(wr_cnt), 32'd255);
    check_model("sat");

`ifdef DEMUX_BROADCAST_EN
    // Broadcast write, broadcast ignored without en, broadcast with clr
    do_reset();
    step(1'b1, 2'd0, 1'b0, 1'b0, 10'h011);
    step(1'b1, 2'd1, 1'b0, 1'b1, 10'h2AA);
    cmp("bcast OA", 32'(oa), 32'h2AA);
    cmp("bcast OD", 32'(od), 32'h2AA);
    cmp("bcast loaded", 32'(loaded), 32'hF);
    cmp("bcast wr_cnt", 32'(wr_cnt), 32'h2);
    step(1'b0, 2'd1, 1'b0, 1'b1, 10'h155);
    cmp("bcast no-en OB", 32'(ob), 32'h2AA);
    cmp("bcast no-en wr_cnt", 32'(wr_cnt), 32'h2);
    step(1'b1, 2'd2, 1'b1, 1'b1, 10'h0F0);
    cmp("bcast clr loaded", 32'(loaded), 32'hF);
    cmp("bcast clr wr_cnt", 32'(wr_cnt), 32'h1);
    check_model("bcast");
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic b;
`ifdef DEMUX_BROADCAST_EN
      b = ($urandom_range(0, 5) == 0);
`else
      b = 1'b0;
`endif
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), b, 10'($urandom_range(0, 1023)));
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
